// File: rtl/observer_update.sv
// Luenberger observer state update: xhat+ = A*xhat + B*uk + L*(y_meas - yhat), Q32.32.
// Optional macro OBSERVER_INNOV_CLAMP_EN additionally clamps the innovation to +/-INNOV_LIM.
module observer_update #(
  parameter logic [63:0] A00       = 64'h0000_0001_0000_0000,
  parameter logic [63:0] A01       = 64'h0,
  parameter logic [63:0] A10       = 64'h0,
  parameter logic [63:0] A11       = 64'h0000_0001_0000_0000,
  parameter logic [63:0] B0        = 64'h0000_0000_8000_0000,
  parameter logic [63:0] B1        = 64'h0,
  parameter logic [63:0] L0        = 64'h0000_0000_4000_0000,
  parameter logic [63:0] L1        = 64'h0,
  parameter logic [63:0] SAT_LIM   = 64'h0000_0008_0000_0000,
  parameter logic [63:0] INNOV_LIM = 64'h0000_0001_0000_0000
) (
  input  logic        clk_1,
  input  logic        ap_rst,
  input  logic        ap_start,
  output logic        ap_done,
  output logic        ap_idle,
  output logic        ap_ready,
  input  logic [63:0] uk,
  input  logic [63:0] y_meas,
  input  logic [63:0] yhat,
  input  logic        yhat_ap_vld,
  input  logic        xhat_address0,
  input  logic        xhat_ce0,
  output logic [63:0] xhat_q0,
  input  logic        xhat_address1,
  input  logic        xhat_ce1,
  output logic [63:0] xhat_q1
);

  // Handshake: ap_start is sampled only in IDLE; ap_done/ap_ready pulse for exactly
  // one cycle exactly 10 cycles later; starts seen while busy are dropped.
  typedef enum logic [1:0] {S_IDLE, S_MAC, S_WRITE, S_DONE} state_t;

  state_t      state, state_next;
  logic [2:0]  k;
  logic [63:0] x0, x1, x_r0, x_r1, uk_r, innov_r, yhat_reg, acc0, acc1;
  logic [63:0] yhat_eff, innov_next, coef, opnd, term, acc_sel;
  logic [127:0] prod;

  function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b);
    logic [64:0] s;
    s = {a[63], a} + {b[63], b};
    if (s[64] != s[63]) sat_add = s[64] ? 64'h8000_0000_0000_0000 : 64'h7FFF_FFFF_FFFF_FFFF;
    else                sat_add = s[63:0];
  endfunction

  function automatic logic [63:0] sat_sub(input logic [63:0] a, input logic [63:0] b);
    logic [64:0] s;
    s = {a[63], a} - {b[63], b};
    if (s[64] != s[63]) sat_sub = s[64] ? 64'h8000_0000_0000_0000 : 64'h7FFF_FFFF_FFFF_FFFF;
    else                sat_sub = s[63:0];
  endfunction

  function automatic logic [63:0] clamp(input logic [63:0] v, input logic [63:0] lim);
    logic [63:0] nlim;
    nlim = ~lim + 64'd1;
    if ($signed(v) > $signed(lim))       clamp = lim;
    else if ($signed(v) < $signed(nlim)) clamp = nlim;
    else                                 clamp = v;
  endfunction

  assign ap_done  = (state == S_DONE);
  assign ap_ready = ap_done;
  assign ap_idle  = (state == S_IDLE) && !ap_start;

  // A yhat arriving in the start cycle bypasses the register so it is used immediately.
  assign yhat_eff = yhat_ap_vld ? yhat : yhat_reg;

`ifdef OBSERVER_INNOV_CLAMP_EN
  assign innov_next = clamp(sat_sub(y_meas, yhat_eff), INNOV_LIM);
`else
  logic unused_innov_lim;
  assign unused_innov_lim = ^INNOV_LIM;
  assign innov_next = sat_sub(y_meas, yhat_eff);
`endif

  always_comb begin
    coef = 64'h0;
    unique case (k)
      3'd0: coef = A00;
      3'd1: coef = A01;
      3'd2: coef = B0;
      3'd3: coef = L0;
      3'd4: coef = A10;
      3'd5: coef = A11;
      3'd6: coef = B1;
      3'd7: coef = L1;
      default: coef = 64'h0;
    endcase
  end

  always_comb begin
    opnd = 64'h0;
    unique case (k[1:0])
      2'd0: opnd = x_r0;
      2'd1: opnd = x_r1;
      2'd2: opnd = uk_r;
      2'd3: opnd = innov_r;
      default: opnd = 64'h0;
    endcase
  end

  // Shared multiplier: sign-extended operands give the exact signed 128-bit product.
  assign prod    = {{64{coef[63]}}, coef} * {{64{opnd[63]}}, opnd};
  assign term    = prod[95:32];
  assign acc_sel = k[2] ? acc1 : acc0;

  logic unused_prod;
  assign unused_prod = ^{prod[127:96], prod[31:0]};

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:  if (ap_start) state_next = S_MAC;
      S_MAC:   if (k == 3'd7) state_next = S_WRITE;
      S_WRITE: state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_1) begin
    if (ap_rst) state <= S_IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk_1) begin
    if (ap_rst) begin
      k        <= 3'd0;
      x0       <= 64'h0;
      x1       <= 64'h0;
      x_r0     <= 64'h0;
      x_r1     <= 64'h0;
      uk_r     <= 64'h0;
      innov_r  <= 64'h0;
      yhat_reg <= 64'h0;
      acc0     <= 64'h0;
      acc1     <= 64'h0;
      xhat_q0  <= 64'h0;
      xhat_q1  <= 64'h0;
    end else begin
      if (yhat_ap_vld) yhat_reg <= yhat;
      // Reads see pre-write contents when they coincide with WRITE.
      if (xhat_ce0) xhat_q0 <= xhat_address0 ? x1 : x0;
      if (xhat_ce1) xhat_q1 <= xhat_address1 ? x1 : x0;
      unique case (state)
        S_IDLE: begin
          if (ap_start) begin
            uk_r    <= uk;
            x_r0    <= x0;
            x_r1    <= x1;
            innov_r <= innov_next;
            acc0    <= 64'h0;
            acc1    <= 64'h0;
            k       <= 3'd0;
          end
        end
        S_MAC: begin
          k <= k + 3'd1;
          if (k[2]) acc1 <= sat_add(acc_sel, term);
          else      acc0 <= sat_add(acc_sel, term);
        end
        S_WRITE: begin
          x0 <= clamp(acc0, SAT_LIM);
          x1 <= clamp(acc1, SAT_LIM);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_observer_update.sv
// Directed testbench for observer_update with hand-computed Q32.32 expectations.
module tb_observer_update;

  logic        clk_1 = 1'b0;
  logic        ap_rst, ap_start, ap_done, ap_idle, ap_ready;
  logic [63:0] uk, y_meas, yhat;
  logic        yhat_ap_vld;
  logic        xhat_address0, xhat_ce0, xhat_address1, xhat_ce1;
  logic [63:0] xhat_q0, xhat_q1;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [63:0] ONE     = 64'h0000_0001_0000_0000;
  localparam logic [63:0] TWO     = 64'h0000_0002_0000_0000;
  localparam logic [63:0] P100    = 64'h0000_0064_0000_0000;
  localparam logic [63:0] M100    = 64'hFFFF_FF9C_0000_0000;
  localparam logic [63:0] M1      = 64'hFFFF_FFFF_0000_0000;
  localparam logic [63:0] HALF    = 64'h0000_0000_8000_0000;
  localparam logic [63:0] P8      = 64'h0000_0008_0000_0000;
  localparam logic [63:0] M8      = 64'hFFFF_FFF8_0000_0000;
  localparam logic [63:0] M6_5    = 64'hFFFF_FFF9_8000_0000;
  localparam logic [63:0] M0_25   = 64'hFFFF_FFFF_C000_0000;

  observer_update dut (
    .clk_1(clk_1), .ap_rst(ap_rst), .ap_start(ap_start), .ap_done(ap_done),
    .ap_idle(ap_idle), .ap_ready(ap_ready), .uk(uk), .y_meas(y_meas), .yhat(yhat),
    .yhat_ap_vld(yhat_ap_vld), .xhat_address0(xhat_address0), .xhat_ce0(xhat_ce0),
    .xhat_q0(xhat_q0), .xhat_address1(xhat_address1), .xhat_ce1(xhat_ce1),
    .xhat_q1(xhat_q1)
  );

  // Clock and reset
  always #5 clk_1 = ~clk_1;

  task automatic tick();
    @(posedge clk_1);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Driver tasks
  task automatic run_update(input string tag, input logic [63:0] u, input logic [63:0] y);
    int lat;
    uk = u;
    y_meas = y;
    ap_start = 1'b1;
    tick();
    ap_start = 1'b0;
    lat = 0;
    while (ap_done !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'd9);
    check({tag, "_ready"}, 64'(ap_ready), 64'd1);
    tick();
  endtask

  task automatic read_x(output logic [63:0] r0, output logic [63:0] r1);
    xhat_ce0 = 1'b1; xhat_address0 = 1'b0;
    xhat_ce1 = 1'b1; xhat_address1 = 1'b1;
    tick();
    xhat_ce0 = 1'b0; xhat_ce1 = 1'b0;
    r0 = xhat_q0;
    r1 = xhat_q1;
  endtask

  logic [63:0] r0, r1;
  int done_cnt, idle_cnt;

  initial begin
    ap_rst = 1'b1; ap_start = 1'b0; uk = '0; y_meas = '0; yhat = '0; yhat_ap_vld = 1'b0;
    xhat_address0 = 1'b0; xhat_ce0 = 1'b0; xhat_address1 = 1'b0; xhat_ce1 = 1'b0;
    tick(); tick();
    ap_rst = 1'b0;
    check("rst_idle", 64'(ap_idle), 64'd1);
    check("rst_done", 64'(ap_done), 64'd0);
    check("rst_q0", xhat_q0, 64'h0);
    check("rst_q1", xhat_q1, 64'h0);

    // 1: x0 = 0.5*1.0
    run_update("t1", ONE, 64'h0);
    read_x(r0, r1);
    check("t1_x0", r0, HALF);
    check("t1_x1", r1, 64'h0);

    // 2: yhat pulse of 0, innovation 2.0
    yhat = 64'h0; yhat_ap_vld = 1'b1; tick(); yhat_ap_vld = 1'b0;
    run_update("t2", ONE, TWO);
    read_x(r0, r1);
`ifdef OBSERVER_INNOV_CLAMP_EN
    check("t2_x0", r0, 64'h0000_0001_4000_0000);
`else
    check("t2_x0", r0, 64'h0000_0001_8000_0000);
`endif
    check("t2_x1", r1, 64'h0);

    // 3a: large positive input clamps to +8.0
    run_update("t3a", P100, TWO);
    read_x(r0, r1);
    check("t3a_x0", r0, P8);

    // 3b + 4: negative clamp, with reads landing in the WRITE cycle
    uk = M100; y_meas = 64'h0;
    ap_start = 1'b1; tick(); ap_start = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    check("t4_done_in_write", 64'(ap_done), 64'd0);
    xhat_ce0 = 1'b1; xhat_address0 = 1'b0;
    xhat_ce1 = 1'b1; xhat_address1 = 1'b1;
    tick();
    check("t4_q0_old", xhat_q0, P8);
    check("t4_q1_old", xhat_q1, 64'h0);
    check("t4_done", 64'(ap_done), 64'd1);
    tick();
    xhat_ce0 = 1'b0; xhat_ce1 = 1'b0;
    check("t4_q0_new", xhat_q0, M8);
    check("t4_q1_new", xhat_q1, 64'h0);
    check("t4_idle", 64'(ap_idle), 64'd1);

    // 5: ap_start held high, one done every 11 cycles, never idle
    uk = ONE; y_meas = 64'h0;
    done_cnt = 0; idle_cnt = 0;
    ap_start = 1'b1;
    for (int i = 1; i <= 33; i++) begin
      tick();
      check("t5_done_slot", 64'(ap_done), ((i % 11) == 10) ? 64'd1 : 64'd0);
      if (ap_done) done_cnt++;
      if (ap_idle) idle_cnt++;
    end
    ap_start = 1'b0;
    check("t5_done_count", 64'(done_cnt), 64'd3);
    check("t5_idle_count", 64'(idle_cnt), 64'd0);
    read_x(r0, r1);
    check("t5_x0", r0, M6_5);

    // 6: reset at T+5 aborts the update
    uk = ONE; y_meas = TWO;
    ap_start = 1'b1; tick(); ap_start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    ap_rst = 1'b1; tick(); ap_rst = 1'b0;
    check("t6_idle", 64'(ap_idle), 64'd1);
    check("t6_q0", xhat_q0, 64'h0);
    done_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (ap_done) done_cnt++;
    end
    check("t6_no_done", 64'(done_cnt), 64'd0);
    read_x(r0, r1);
    check("t6_x0", r0, 64'h0);
    check("t6_x1", r1, 64'h0);

    // 7: registered yhat, then same-cycle yhat bypass
    yhat = ONE; yhat_ap_vld = 1'b1; tick(); yhat_ap_vld = 1'b0;
    run_update("t7a", 64'h0, 64'h0);
    read_x(r0, r1);
    check("t7a_x0", r0, M0_25);
    uk = 64'h0; y_meas = 64'h0; yhat = M1; yhat_ap_vld = 1'b1; ap_start = 1'b1;
    tick();
    yhat_ap_vld = 1'b0; ap_start = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    read_x(r0, r1);
    check("t7b_x0", r0, 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
